// File: rtl/btree_find.sv
// Root-to-leaf search controller for a bank of combinational node-index blocks.
// Presents one key/address pair per cycle and descends on the bank's child pointer.
module btree_find #(
    parameter int KEY_WIDTH     = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int ROOT_ADDRESS  = 1,
    parameter int MAX_DEPTH     = 8,
    localparam int DW           = $clog2(MAX_DEPTH + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [KEY_WIDTH-1:0]     key,
    output logic                     busy,
    output logic                     done,
    output logic                     found,
    output logic [DATA_WIDTH-1:0]    data,
    output logic [DW-1:0]            depth,
    output logic                     error,
    output logic [KEY_WIDTH-1:0]     search_key,
    output logic [ADDRESS_WIDTH-1:0] search_address,
    input  logic                     node_found,
    input  logic [DATA_WIDTH-1:0]    node_data,
    input  logic [ADDRESS_WIDTH-1:0] node_next
);

    typedef enum logic {IDLE, SEARCH} state_t;

    localparam logic [DW-1:0]            MAX_D = DW'(MAX_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] ROOT  = ADDRESS_WIDTH'(ROOT_ADDRESS);

    state_t                   state_q, state_d;
    logic                     done_q, done_d;
    logic                     found_q, found_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [DW-1:0]            depth_q, depth_d;
    logic                     error_q, error_d;
    logic [KEY_WIDTH-1:0]     key_q, key_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DW-1:0]            depth_inc;

    assign depth_inc = (depth_q == MAX_D) ? depth_q : depth_q + DW'(1);

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        found_d = found_q;
        data_d  = data_q;
        depth_d = depth_q;
        error_d = error_q;
        key_d   = key_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key;
                    addr_d  = ROOT;
                    depth_d = '0;
                    found_d = 1'b0;
                    data_d  = '0;
                    error_d = 1'b0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                depth_d = depth_inc;
                if (node_found) begin
                    found_d = 1'b1;
                    data_d  = node_data;
                    done_d  = 1'b1;
                    addr_d  = '0;
                    state_d = IDLE;
                end else if (node_next == '0) begin
                    found_d = 1'b0;
                    data_d  = '0;
                    done_d  = 1'b1;
                    addr_d  = '0;
                    state_d = IDLE;
                end else if (depth_inc == MAX_D) begin
                    // Depth limit guards against cyclic or over-deep trees
                    error_d = 1'b1;
                    found_d = 1'b0;
                    data_d  = '0;
                    done_d  = 1'b1;
                    addr_d  = '0;
                    state_d = IDLE;
                end else begin
                    addr_d = node_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            data_q  <= '0;
            depth_q <= '0;
            error_q <= 1'b0;
            key_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            found_q <= found_d;
            data_q  <= data_d;
            depth_q <= depth_d;
            error_q <= error_d;
            key_q   <= key_d;
            addr_q  <= addr_d;
        end
    end

    assign busy           = (state_q == SEARCH);
    assign done           = done_q;
    assign found          = found_q;
    assign data           = data_q;
    assign depth          = depth_q;
    assign error          = error_q;
    assign search_key     = key_q;
    assign search_address = addr_q;

endmodule

// File: tb/tb_btree_find.sv
// Bench for btree_find: a table-backed node bank, directed vectors,
// hand-written corner sequences and random trees against a tree-walk model.
module tb_btree_find;

    localparam int MAXD = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] key;
    logic       busy, done, found, error;
    logic [7:0] data;
    logic [3:0] depth;
    logic [7:0] search_key, search_address;
    logic       node_found;
    logic [7:0] node_data, node_next;

    always #5 clk = ~clk;

    btree_find dut (
        .clock(clk), .reset(reset), .start(start), .key(key),
        .busy(busy), .done(done), .found(found), .data(data),
        .depth(depth), .error(error), .search_key(search_key),
        .search_address(search_address), .node_found(node_found),
        .node_data(node_data), .node_next(node_next)
    );

    // Node bank contents: blocks 1..15, indexed by key
    bit       hit_t   [16][256];
    bit [7:0] dat_t   [16][256];
    bit [7:0] child_t [16][256];
    bit       cyclic;

    int tests = 0;
    int fails = 0;
    int addr_seq[$];
    int exp_seq[$];

    task automatic bank_ref(input int a, input int k,
                            output bit f, output bit [7:0] d,
                            output bit [7:0] n);
        f = 0; d = 0; n = 0;
        if (a != 0 && cyclic) n = 8'd1;
        else if (a > 0 && a < 16) begin
            f = hit_t[a][k];
            d = f ? dat_t[a][k] : 8'd0;
            n = f ? 8'd0 : child_t[a][k];
        end
    endtask

    always_comb begin
        bit f;
        bit [7:0] d, n;
        bank_ref(int'(search_address), int'(search_key), f, d, n);
        node_found = f;
        node_data  = d;
        node_next  = n;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_tree();
        for (int a = 0; a < 16; a++)
            for (int k = 0; k < 256; k++) begin
                hit_t[a][k] = 0; dat_t[a][k] = 0; child_t[a][k] = 0;
            end
        cyclic = 0;
    endtask

    // Walk the tree level by level from the root
    task automatic ref_walk(input int k, output bit f, output bit [7:0] d,
                            output int lv, output bit e);
        int a;
        bit hf;
        bit [7:0] hd, hn;
        a = 1; f = 0; d = 0; lv = 0; e = 0;
        exp_seq.delete();
        for (int l = 1; l <= MAXD; l++) begin
            exp_seq.push_back(a);
            lv = l;
            bank_ref(a, k, hf, hd, hn);
            if (hf) begin f = 1; d = hd; return; end
            if (hn == 0) return;
            if (l == MAXD) begin e = 1; return; end
            a = int'(hn);
        end
    endtask

    // Start a search; returns edges from acceptance to done
    task automatic search(input logic [7:0] k, output int lat);
        @(negedge clk);
        start = 1'b1; key = k;
        @(posedge clk); #1;
        start = 1'b0; key = 8'($urandom);
        addr_seq.delete();
        lat = 0;
        while (lat < 40) begin
            if (busy) begin
                addr_seq.push_back(int'(search_address));
                check("search_key_held", int'(search_key), int'(k));
            end
            if (busy && done) check("busy_done_overlap", 1, 0);
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
    endtask

    task automatic check_seq(input string name);
        check({name, "_len"}, addr_seq.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < addr_seq.size(); i++)
            check({name, "_addr"}, addr_seq[i], exp_seq[i]);
    endtask

    typedef struct {
        logic [7:0] key;
        bit         exp_found;
        logic [7:0] exp_data;
        int         exp_depth;
        bit         exp_err;
    } vec_t;

    vec_t vt[5];

    initial begin
        int lat, lv, dones;
        bit f, e;
        bit [7:0] d;

        vt[0] = '{8'd5, 1'b1, 8'h55, 1, 1'b0};
        vt[1] = '{8'd9, 1'b0, 8'h00, 2, 1'b0};
        vt[2] = '{8'd2, 1'b1, 8'hA2, 3, 1'b0};
        vt[3] = '{8'd8, 1'b0, 8'h00, 1, 1'b0};
        vt[4] = '{8'd5, 1'b1, 8'h55, 1, 1'b0};

        clear_tree();
        hit_t[1][5] = 1; dat_t[1][5] = 8'h55;
        child_t[1][9] = 8'd3;
        child_t[1][2] = 8'd4;
        child_t[4][2] = 8'd7;
        hit_t[7][2] = 1; dat_t[7][2] = 8'hA2;

        reset = 1'b1; start = 1'b0; key = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_found", found, 0);
        check("rst_data", data, 0);
        check("rst_depth", depth, 0);
        check("rst_error", error, 0);
        check("rst_skey", search_key, 0);
        check("rst_addr", search_address, 0);
        @(negedge clk); reset = 1'b0;

        foreach (vt[i]) begin
            search(vt[i].key, lat);
            check("vec_latency", lat, vt[i].exp_depth);
            check("vec_done", done, 1);
            check("vec_found", found, vt[i].exp_found);
            check("vec_data", data, vt[i].exp_data);
            check("vec_depth", depth, vt[i].exp_depth);
            check("vec_error", error, vt[i].exp_err);
            check("vec_idle_addr", search_address, 0);
            if (vt[i].key == 8'd2) begin
                exp_seq = '{1, 4, 7};
                check_seq("three_level");
            end
        end

        // Held results and single done pulse after completion
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("found_held", found, 1);
        check("data_held", data, 8'h55);

        // Second start while busy must be ignored
        @(negedge clk); start = 1'b1; key = 8'd2;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); start = 1'b1; key = 8'd1;
        @(posedge clk); #1; start = 1'b0;
        dones = 0; lat = 1;
        for (int c = 0; c < 12; c++) begin
            if (done) dones++;
            if (done && dones == 1) begin
                check("busy_start_lat", lat, 3);
                check("busy_start_found", found, 1);
                check("busy_start_data", data, 8'hA2);
                check("busy_start_depth", depth, 3);
            end
            @(posedge clk); #1; lat++;
        end
        check("busy_start_dones", dones, 1);

        // Reset at level 2 of a three-level search
        @(negedge clk); start = 1'b1; key = 8'd2;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        check("mid_level2_addr", search_address, 4);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", search_address, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_depth", depth, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_no_done", done, 0);
        search(8'd5, lat);
        check("post_rst_lat", lat, 1);
        check("post_rst_found", found, 1);
        check("post_rst_data", data, 8'h55);

        // Cyclic tree trips the depth limit
        cyclic = 1;
        search(8'd7, lat);
        check("cyc_lat", lat, 8);
        check("cyc_error", error, 1);
        check("cyc_found", found, 0);
        check("cyc_data", data, 0);
        check("cyc_depth", depth, 8);
        cyclic = 0;

        // Random trees against the tree-walk model
        for (int it = 0; it < 40; it++) begin
            bit [7:0] rk;
            if (it % 8 == 0) begin
                for (int a = 1; a < 16; a++)
                    for (int k = 0; k < 16; k++) begin
                        hit_t[a][k]   = ($urandom_range(3) == 0);
                        dat_t[a][k]   = 8'($urandom);
                        child_t[a][k] = 8'($urandom_range(15));
                    end
            end
            rk = 8'($urandom_range(15));
            ref_walk(int'(rk), f, d, lv, e);
            search(rk, lat);
            check("rnd_latency", lat, lv);
            check("rnd_found", found, f);
            check("rnd_data", data, d);
            check("rnd_depth", depth, lv);
            check("rnd_error", error, e);
            check_seq("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
